// File: rtl/ch_aggregator_if.sv
// Memory-side bus of the cluster-head aggregator (2048 x 16b node memory view).
// data_in returns mem[address] one cycle after address is presented; wr_en writes data_out.
interface ch_aggregator_if;
  logic [10:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        wr_en;

  modport master (output address, output data_out, output wr_en, input data_in);
  modport slave  (input address, input data_out, input wr_en, output data_in);
endinterface

// File: rtl/ch_aggregator.sv
// Cluster-head aggregator: reads member count and words from node memory, computes
// sum/min/max and the integer mean (24-step restoring divide), writes the mean back.
module ch_aggregator #(
  parameter logic [10:0] CNT_ADDR    = 11'h100,
  parameter logic [10:0] DATA_BASE   = 11'h101,
  parameter logic [10:0] RESULT_ADDR = 11'h1F0,
  parameter int          MAX_PKTS    = 64
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            en,
  ch_aggregator_if.master mem,
  output logic [15:0]     agg_data,
  output logic [15:0]     agg_min,
  output logic [15:0]     agg_max,
  output logic            clamped,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);
  // Start/complete handshake: en is a level sampled only while idle (busy=0); each accepted
  // start yields exactly one done pulse, and en seen in any other state is dropped.
  typedef enum logic [2:0] {IDLE, RD_CNT, RD_DATA, DIVIDE, WRITE, FINISH} state_t;

  localparam logic [7:0] MAX_N = 8'(MAX_PKTS);

  state_t      state, state_next;
  logic [7:0]  n, cyc;
  logic [4:0]  div_cnt;
  logic [23:0] sum, dq, rem, div_src, rem_next;
  logic [24:0] rem_shift;
  logic [15:0] min_acc, max_acc;
  logic [7:0]  cnt_raw;
  logic        cnt_over, q_bit;

  assign cnt_raw  = mem.data_in[7:0];
  assign cnt_over = cnt_raw > MAX_N;

  // First divide step takes the dividend straight from sum, which settles on the same edge
  // the FSM enters DIVIDE.
  always_comb begin
    div_src   = (div_cnt == 5'd0) ? sum : dq;
    rem_shift = {rem, div_src[23]};
    q_bit     = rem_shift >= {17'd0, n};
    rem_next  = q_bit ? 24'(rem_shift - {17'd0, n}) : rem_shift[23:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RD_CNT;
      RD_CNT:  if (cyc[0]) state_next = RD_DATA;
      RD_DATA: if (cyc == n) state_next = (n == 8'd0) ? FINISH : DIVIDE;
      DIVIDE:  if (div_cnt == 5'd24) state_next = WRITE;
      WRITE:   state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign mem.wr_en = (state == WRITE);
  assign dbg_state = state;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem.address  <= '0;
      mem.data_out <= '0;
      agg_data     <= '0;
      agg_min      <= '0;
      agg_max      <= '0;
      clamped      <= 1'b0;
      n            <= '0;
      cyc          <= '0;
      div_cnt      <= '0;
      sum          <= '0;
      dq           <= '0;
      rem          <= '0;
      min_acc      <= '0;
      max_acc      <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          mem.address <= CNT_ADDR;
          sum         <= '0;
          clamped     <= 1'b0;
          min_acc     <= 16'hFFFF;
          max_acc     <= '0;
          cyc         <= '0;
        end
        RD_CNT: begin
          cyc <= cyc[0] ? 8'd0 : cyc + 8'd1;
          if (cyc[0]) begin
            n       <= cnt_over ? MAX_N : cnt_raw;
            clamped <= cnt_over;
            if (cnt_raw != 8'd0) mem.address <= DATA_BASE;
          end
        end
        RD_DATA: begin
          // Address i is issued at cyc==i-1 and its word arrives two edges later.
          cyc <= cyc + 8'd1;
          if ((cyc + 8'd1) < n) mem.address <= DATA_BASE + 11'(cyc + 8'd1);
          if (cyc != 8'd0) begin
            sum <= sum + {8'd0, mem.data_in};
            if (mem.data_in < min_acc) min_acc <= mem.data_in;
            if (mem.data_in > max_acc) max_acc <= mem.data_in;
          end
          if (cyc == n) begin
            rem     <= '0;
            div_cnt <= '0;
            if (n == 8'd0) begin
              agg_data <= '0;
              agg_min  <= '0;
              agg_max  <= '0;
            end
          end
        end
        DIVIDE: begin
          if (div_cnt != 5'd24) begin
            rem     <= rem_next;
            dq      <= {div_src[22:0], q_bit};
            div_cnt <= div_cnt + 5'd1;
          end else begin
            mem.address  <= RESULT_ADDR;
            mem.data_out <= dq[15:0];
            agg_data     <= dq[15:0];
            agg_min      <= min_acc;
            agg_max      <= max_acc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
